wasm_immediate_decoder: RTL and testbench
=========================================

// Module: wasm_immediate_decoder
// PURPOSE
//  Consumes the bytecode byte stream that follows an opcode and produces the decoded
//  immediate: LEB128 (u/s, 32/64) or little-endian f32/f64 literal. It sits between
//  instruction fetch and the operand stack; its result feeds const/index ops.
//  It also reports bytes consumed so fetch can advance PC, and a trap code on malformed input.
// PARAMETERS
//  (none; all widths fixed by the wasm spec)
// PORTS
//  clk           in   1   clock, all logic on rising edge
//  reset         in   1   synchronous, active-high
//  start         in   1   begin decoding, sampled only in IDLE
//  kind          in   3   immediate kind, sampled with start
//  in_data       in   8   bytecode byte
//  in_valid      in   1   in_data valid
//  in_ready      out  1   byte accepted when in_valid & in_ready
//  result        out  64  decoded immediate
//  result_valid  out  1   result/bytes_used valid, held until result_ready
//  result_ready  in   1   consumer takes result
//  bytes_used    out  4   bytes consumed (1..10)
//  busy          out  1   state != IDLE
//  trap          out  3   0 none, 1 overlong, 2 bad unused bits, 3 bad kind; sticky
// BEHAVIOUR
//  - Reset: state=IDLE, result=0, result_valid=0, bytes_used=0, in_ready=0, trap=0.
//  - Kinds: 0 ULEB32, 1 SLEB32, 2 ULEB64, 3 SLEB64, 4 F32 (4 B LE), 5 F64 (8 B LE), 6-7 invalid.
//  - FSM IDLE -> COLLECT on start (valid kind); IDLE -> ERROR on start with kind 6/7 (trap=3).
//  - COLLECT: in_ready=1; each accepted byte n (0-based) merged at bits [7n+6:7n] (LEB)
//    or [8n+7:8n] (float); counter increments. LEB ends on byte with bit7=0; float ends
//    at byte 4/8. No byte accepted when in_valid=0; state and counter hold.
//  - COLLECT -> DONE the cycle after the last byte handshake; result_valid=1 in DONE.
//    Latency: result_valid rises 1 cycle after final byte accepted.
//  - DONE: result, bytes_used stable; DONE -> IDLE on result_ready (same-cycle start ignored;
//    start honoured next cycle). in_ready=0 in DONE/IDLE/ERROR.
//  - Width: 32-bit kinds give result[63:32]=0. SLEB32 sign-extends from last byte's bit6
//    to bit31; SLEB64 to bit63. Partial shifts beyond width are truncated.
//  - Limits: 32-bit LEB max 5 bytes, 64-bit max 10. Continuation set on max byte -> trap=1.
//    Max byte checks: ULEB32 bits[6:4]=0; SLEB32 bits[6:3] all equal; ULEB64 bit[6:1]=0;
//    SLEB64 bits[6:0] = 0x00 or 0x7f; violation -> trap=2.
//  - ERROR: sticky, in_ready=0, result_valid=0, busy=1; exit only by reset.
//  - Reset mid-decode: partial accumulator discarded, back to IDLE next cycle.
//  - start while busy: ignored, no trap.
// STRUCTURE
//  - Package wasm_decode_pkg: KIND_* constants, TRAP_* codes, LEB_MAX32=5, LEB_MAX64=10,
//    state enum.
//  - One sub-module leb_final_check (combinational: kind, byte -> trap code) keeps the
//    max-byte rules testable alone; accumulator and FSM stay in the top.
// TESTING
//  - F32 bytes 00 00 00 c0 -> result=64'h00000000_c0000000, bytes_used=4, trap=0.
//  - SLEB32 bytes 7f -> result=64'h00000000_ffffffff, bytes_used=1.
//  - ULEB32 e5 8e 26 with in_valid gaps -> result=624485, bytes_used=3, no lost byte.
//  - ULEB32 80 80 80 80 80 -> trap=1, in_ready=0 after, stays until reset.
//  - SLEB64 ff x9 then 7f -> result=64'hffffffff_ffffffff; 10th byte 3f -> trap=2.
//  - Reset mid-F64 after 3 bytes, then F32 00 00 80 3f -> 64'h00000000_3f800000.

Source files
------------

// File: rtl/wasm_decode_pkg.sv
// wasm_decode_pkg: immediate kinds, trap codes, LEB byte limits and decoder states
package wasm_decode_pkg;
  localparam logic [2:0] KIND_ULEB32 = 3'd0;
  localparam logic [2:0] KIND_SLEB32 = 3'd1;
  localparam logic [2:0] KIND_ULEB64 = 3'd2;
  localparam logic [2:0] KIND_SLEB64 = 3'd3;
  localparam logic [2:0] KIND_F32 = 3'd4;
  localparam logic [2:0] KIND_F64 = 3'd5;
  localparam logic [2:0] TRAP_NONE = 3'd0;
  localparam logic [2:0] TRAP_OVERLONG = 3'd1;
  localparam logic [2:0] TRAP_BAD_BITS = 3'd2;
  localparam logic [2:0] TRAP_BAD_KIND = 3'd3;
  localparam logic [3:0] LEB_MAX32 = 4'd5;
  localparam logic [3:0] LEB_MAX64 = 4'd10;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE, S_ERROR} state_e;
endpackage

// File: rtl/leb_final_check.sv
// leb_final_check: trap code for the last permitted LEB byte (kind, data in; trap out)
module leb_final_check
  import wasm_decode_pkg::*;
(
  input  logic [2:0] kind,
  input  logic [7:0] data,
  output logic [2:0] trap
);
  logic bad;
  always_comb begin
    bad = kind == KIND_ULEB32 ? |data[6:4] :
          kind == KIND_SLEB32 ? !(&data[6:3] || ~|data[6:3]) :
          kind == KIND_ULEB64 ? |data[6:1] :
                                !(&data[6:0] || ~|data[6:0]);
    trap = kind[2] ? TRAP_NONE : data[7] ? TRAP_OVERLONG : bad ? TRAP_BAD_BITS : TRAP_NONE;
  end
endmodule

// File: rtl/wasm_immediate_decoder.sv
// wasm_immediate_decoder: byte stream after an opcode -> LEB128/float immediate, bytes_used, sticky trap
module wasm_immediate_decoder
  import wasm_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  kind,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [3:0]  bytes_used,
  output logic        busy,
  output logic [2:0]  trap
);
  state_e state_q, state_d;
  logic [2:0] kind_q, kind_d, trap_q, trap_d, chk;
  logic [63:0] acc_q, acc_d, merged, sext, fin;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] sh, sh_end;
  logic is_leb, wide, at_max, last;
  leb_final_check u_chk (.kind(kind_q), .data(in_data), .trap(chk));
  always_comb begin
    is_leb = !kind_q[2];
    wide = kind_q[1];
    sh = is_leb ? 7'(cnt_q) * 7'd7 : {cnt_q, 3'b0};
    sh_end = sh + 7'd7;
    merged = is_leb ? acc_q | ({57'b0, in_data[6:0]} << sh) : acc_q | ({56'b0, in_data} << sh);
    sext = merged | (kind_q[0] && in_data[6] ? ~64'd0 << sh_end : 64'd0);
    fin = wide ? sext : {32'd0, sext[31:0]};
    at_max = cnt_q == (wide ? LEB_MAX64 - 4'd1 : LEB_MAX32 - 4'd1);
    last = is_leb ? !in_data[7] : cnt_q == (kind_q == KIND_F64 ? 4'd7 : 4'd3);
    state_d = state_q;
    kind_d = kind_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    trap_d = trap_q;
    if (state_q == S_IDLE && start) begin
      if (kind > KIND_F64) begin
        trap_d = TRAP_BAD_KIND;
        state_d = S_ERROR;
      end else begin
        kind_d = kind;
        acc_d = '0;
        cnt_d = '0;
        state_d = S_COLLECT;
      end
    end else if (state_q == S_COLLECT && in_valid) begin
      cnt_d = cnt_q + 4'd1;
      if (is_leb && at_max && chk != TRAP_NONE) begin
        trap_d = chk;
        state_d = S_ERROR;
      end else begin
        acc_d = last && is_leb ? fin : merged;
        state_d = last ? S_DONE : S_COLLECT;
      end
    end else if (state_q == S_DONE && result_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      trap_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      trap_q <= trap_d;
    end
  end
  assign in_ready = state_q == S_COLLECT;
  assign result_valid = state_q == S_DONE;
  assign busy = state_q != S_IDLE;
  assign result = acc_q;
  assign bytes_used = cnt_q;
  assign trap = trap_q;
endmodule

// File: tb/tb_wasm_immediate_decoder.sv
// tb_wasm_immediate_decoder: directed vectors with hand-computed expectations
module tb_wasm_immediate_decoder;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, result_ready = 0;
  logic [2:0] kind = 0, trap;
  logic [7:0] in_data = 0;
  logic in_ready, result_valid, busy;
  logic [63:0] result;
  logic [3:0] bytes_used;
  int n_cmp = 0, n_bad = 0;
  wasm_immediate_decoder dut (
    .clk(clk), .reset(reset), .start(start), .kind(kind), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .bytes_used(bytes_used), .busy(busy), .trap(trap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [2:0] k);
    @(negedge clk);
    start = 1;
    kind = k;
    @(negedge clk);
    start = 0;
  endtask
  task automatic put(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data = b;
    in_valid = 1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic take();
    @(negedge clk);
    result_ready = 1;
    @(negedge clk);
    result_ready = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask
  task automatic expect_result(input string tag, input logic [63:0] r, input logic [3:0] nb);
    @(negedge clk);
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_result"}, result, r);
    chk({tag, "_bytes"}, bytes_used, nb);
    chk({tag, "_trap"}, trap, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_bytes", bytes_used, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_trap", trap, 0);
    chk("rst_busy", busy, 0);
    go(3'd4);
    chk("f32_in_ready", in_ready, 1);
    put(8'h00); put(8'h00); put(8'h00); put(8'hc0);
    expect_result("f32", 64'h00000000_c0000000, 4'd4);
    repeat (3) @(negedge clk);
    chk("done_hold_valid", result_valid, 1);
    chk("done_hold_result", result, 64'h00000000_c0000000);
    take();
    chk("after_take_busy", busy, 0);
    chk("after_take_valid", result_valid, 0);
    go(3'd1);
    put(8'h7f);
    expect_result("sleb32_m1", 64'h00000000_ffffffff, 4'd1);
    take();
    go(3'd0);
    put(8'he5);
    repeat (2) @(negedge clk);
    chk("gap_bytes", bytes_used, 1);
    chk("gap_busy", busy, 1);
    start = 1;
    kind = 3'd7;
    @(negedge clk);
    start = 0;
    chk("busy_start_trap", trap, 0);
    chk("busy_start_ready", in_ready, 1);
    put(8'h8e);
    repeat (3) @(negedge clk);
    put(8'h26);
    expect_result("uleb32_gap", 64'd624485, 4'd3);
    result_ready = 1;
    start = 1;
    kind = 3'd0;
    @(negedge clk);
    result_ready = 0;
    chk("done_start_ignored", busy, 0);
    @(negedge clk);
    start = 0;
    chk("start_next_cycle", busy, 1);
    put(8'h05);
    expect_result("uleb32_5", 64'd5, 4'd1);
    take();
    go(3'd1);
    put(8'h80); put(8'h7f);
    expect_result("sleb32_m128", 64'h00000000_ffffff80, 4'd2);
    take();
    go(3'd0);
    put(8'hff); put(8'hff); put(8'hff); put(8'hff); put(8'h0f);
    expect_result("uleb32_max", 64'h00000000_ffffffff, 4'd5);
    take();
    go(3'd2);
    put(8'h80); put(8'h80); put(8'h80); put(8'h80); put(8'h10);
    expect_result("uleb64_2p32", 64'h00000001_00000000, 4'd5);
    take();
    go(3'd3);
    for (int i = 0; i < 9; i++) put(8'hff);
    put(8'h7f);
    expect_result("sleb64_m1", 64'hffffffff_ffffffff, 4'd10);
    take();
    go(3'd5);
    put(8'h11); put(8'h22); put(8'h33);
    do_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_bytes", bytes_used, 0);
    go(3'd4);
    put(8'h00); put(8'h00); put(8'h80); put(8'h3f);
    expect_result("f32_one", 64'h00000000_3f800000, 4'd4);
    take();
    go(3'd3);
    for (int i = 0; i < 9; i++) put(8'hff);
    put(8'h3f);
    @(negedge clk);
    chk("sleb64_bad_trap", trap, 2);
    chk("sleb64_bad_valid", result_valid, 0);
    chk("sleb64_bad_ready", in_ready, 0);
    chk("sleb64_bad_busy", busy, 1);
    do_reset();
    chk("rst_clears_trap", trap, 0);
    go(3'd0);
    put(8'hff); put(8'hff); put(8'hff); put(8'hff); put(8'h1f);
    @(negedge clk);
    chk("uleb32_bad_trap", trap, 2);
    do_reset();
    go(3'd0);
    for (int i = 0; i < 5; i++) put(8'h80);
    @(negedge clk);
    chk("overlong_trap", trap, 1);
    chk("overlong_ready", in_ready, 0);
    in_valid = 1;
    in_data = 8'h00;
    start = 1;
    repeat (4) @(negedge clk);
    in_valid = 0;
    start = 0;
    chk("overlong_sticky", trap, 1);
    chk("overlong_busy", busy, 1);
    chk("overlong_no_valid", result_valid, 0);
    do_reset();
    chk("overlong_rst_trap", trap, 0);
    go(3'd6);
    @(negedge clk);
    chk("badkind_trap", trap, 3);
    chk("badkind_busy", busy, 1);
    chk("badkind_ready", in_ready, 0);
    do_reset();
    go(3'd7);
    chk("badkind7_trap", trap, 3);
    do_reset();
    chk("final_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
